// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// multicycle_control_fsm_if : decode inputs, datapath strobes and status
// Rev 1.0
// ============================================================================
interface multicycle_control_fsm_if;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        alu_src_b;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        halted;
    logic        error;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, wb_sel, alu_src_b, alu_op, state, instret, halted, error
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, wb_sel, alu_src_b, alu_op, state, instret, halted, error
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// multicycle_control_fsm : RV32I multi-cycle sequencer with memory watchdog
// Rev 1.0
// ============================================================================
module multicycle_control_fsm #(
    parameter int TIMEOUT = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        error_q, error_d;
    logic [15:0] wdog_q, wdog_d;

    logic        w_waiting, w_timeout, w_taken;
    logic        w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write;
    logic        w_pc_src, w_reg_write, w_alu_src_b;
    logic [1:0]  w_wb_sel;
    logic [3:0]  w_alu_op;

    always_comb begin
        state_d     = state_q;
        instret_d   = instret_q;
        error_d     = error_q;
        wdog_d      = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = 2'd0;
        w_alu_src_b = 1'b0;
        w_alu_op    = 4'b0000;

        // Watchdog only runs while a memory access is outstanding; a ready on
        // the terminal count still completes the access.
        w_waiting = (state_q == S_FETCH) || (state_q == S_MEM);
        w_timeout = w_waiting && !bus.mem_ready && (wdog_q == c_TIMEOUT);
        w_taken   = ((bus.funct3 == 3'b000) && bus.zero) ||
                    ((bus.funct3 == 3'b001) && !bus.zero);
        if (w_waiting && !bus.mem_ready && !w_timeout)
            wdog_d = wdog_q + 16'd1;

        case (state_q)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    state_d    = S_DECODE;
                end else if (w_timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_R, c_OP_I, c_OP_LW, c_OP_SW, c_OP_BR, c_OP_JAL:
                        state_d = S_EXEC;
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b0;
                    end
                endcase
            end
            S_EXEC: begin
                case (bus.opcode)
                    c_OP_R: begin
                        w_alu_op = {bus.funct7b5, bus.funct3};
                        state_d  = S_WB;
                    end
                    c_OP_I: begin
                        w_alu_src_b = 1'b1;
                        w_alu_op    = {(bus.funct3 == 3'b101) & bus.funct7b5, bus.funct3};
                        state_d     = S_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        w_alu_src_b = 1'b1;
                        state_d     = S_MEM;
                    end
                    c_OP_BR: begin
                        w_alu_op   = 4'b1000;
                        w_pc_write = w_taken;
                        w_pc_src   = w_taken;
                        state_d    = S_FETCH;
                        instret_d  = instret_q + 32'd1;
                    end
                    c_OP_JAL: begin
                        w_pc_write  = 1'b1;
                        w_pc_src    = 1'b1;
                        w_reg_write = 1'b1;
                        w_wb_sel    = 2'd2;
                        state_d     = S_FETCH;
                        instret_d   = instret_q + 32'd1;
                    end
                    default: begin
                        state_d = S_HALT;
                        error_d = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                w_iord      = 1'b1;
                w_mem_read  = (bus.opcode == c_OP_LW);
                w_mem_write = (bus.opcode != c_OP_LW);
                if (bus.mem_ready) begin
                    if (bus.opcode == c_OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        state_d   = S_FETCH;
                        instret_d = instret_q + 32'd1;
                    end
                end else if (w_timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_wb_sel    = (bus.opcode == c_OP_LW) ? 2'd1 : 2'd0;
                state_d     = S_FETCH;
                instret_d   = instret_q + 32'd1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing reaches the datapath mid-reset.
    assign bus.mem_read  = reset & w_mem_read;
    assign bus.mem_write = reset & w_mem_write;
    assign bus.iord      = reset & w_iord;
    assign bus.ir_write  = reset & w_ir_write;
    assign bus.pc_write  = reset & w_pc_write;
    assign bus.pc_src    = reset & w_pc_src;
    assign bus.reg_write = reset & w_reg_write;
    assign bus.wb_sel    = reset ? w_wb_sel : 2'd0;
    assign bus.alu_src_b = reset & w_alu_src_b;
    assign bus.alu_op    = reset ? w_alu_op : 4'b0000;
    assign bus.state     = state_q;
    assign bus.instret   = instret_q;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.error     = error_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            error_q   <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            error_q   <= error_d;
            wdog_q    <= wdog_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the RV32I datapath: drives the PC, instruction register, register file, ALU, and a shared single-port instruction/data memory through FETCH/DECODE/EXEC/MEM/WB. It replaces single-cycle decode wherever memory has variable latency. It handles a ready-based memory handshake with a watchdog, counts retired instructions, and halts on illegal opcodes or memory timeouts.

## Interface
- TIMEOUT, 16: maximum number of wait cycles for `mem_ready` before halting with an error (1..65535).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- opcode  in  7  instruction[6:0] from the instruction register (valid from DECODE onward)
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read / mem_write  out  1  memory request strobes
- iord  out  1  0 = PC address, 1 = ALU-result address
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+4, 1 = branch/jump target (old_pc + imm)
- reg_write  out  1  register file write enable
- wb_sel  out  2  0 = ALU result, 1 = memory data, 2 = old_pc+4
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  4  {f7b5, f3} coding: 0000 ADD, 1000 SUB
- state  out  3  current state (debug/verification)
- instret  out  32  retired-instruction count
- halted  out  1  in HALT
- error  out  1  halt cause: 1 = memory timeout, 0 = illegal opcode

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. `state`, `instret`, `error`, and the wait counter are registered. Strobes are combinational from state, opcode, funct, zero, and mem_ready.
- **FETCH:** mem_read=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- **DECODE:** no strobes. Legal opcodes go to EXEC: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BRANCH, 1101111 JAL. Any other opcode goes to HALT with error=0.
- **EXEC by opcode:**
  - R-type: alu_src_b=0, alu_op={funct7b5,funct3}, then WB.
  - I-ALU: alu_src_b=1, alu_op={funct3==101 ? funct7b5 : 0, funct3}, then WB.
  - LW/SW: alu_src_b=1, alu_op=ADD, then MEM.
  - BRANCH: alu_src_b=0, alu_op=SUB. Taken = (funct3==000 & zero) | (funct3==001 & ~zero). If taken, pc_write=1 and pc_src=1. Then FETCH, and instret increments.
  - JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=2. Then FETCH, and instret increments.
- **MEM:** iord=1; mem_read for LW, mem_write for SW. On mem_ready, LW goes to WB; SW goes to FETCH and instret increments.
- **WB:** reg_write=1. wb_sel=1 for LW, else 0. Then FETCH, and instret increments.
- **HALT:** all strobes 0; the block stays in HALT until reset.
- **Watchdog:**
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each FETCH/MEM cycle without mem_ready.
  - When the count reaches TIMEOUT with mem_ready still low, the next state is HALT and error=1.
  - mem_ready on the same cycle the count reaches TIMEOUT wins: the access completes normally.
- mem_ready is ignored outside FETCH/MEM.
- instret wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (reset=0 at posedge) sets state=FETCH, instret=0, error=0, and watchdog=0. While reset=0, every strobe output is forced to 0, regardless of state.
- Reset mid-instruction aborts the instruction. No partial writes occur after the reset edge, and the first cycle after release is FETCH.
- Latency with zero-wait memory (mem_ready high on first request cycle):
  - R, I-ALU, SW: 4 cycles.
  - LW: 5 cycles.
  - BRANCH, JAL: 3 cycles.
- Each wait cycle in FETCH/MEM adds 1 cycle.
- Strobes hold steady for the entire FETCH/MEM wait.
- mem_read and mem_write are never both 1.
- pc_write and ir_write pulse exactly once per fetch.
- instret updates on the clock edge that leaves the final state of an instruction.

## Test plan
- **Reset and R-type, zero-wait memory:** after reset release with opcode=0110011, funct3=000, funct7b5=1 → states 0,1,2,4,0; alu_op=1000 in EXEC; reg_write pulses once in WB; instret=1 after 4 cycles.
- **LW with 3 wait cycles in MEM:** mem_read and iord=1 are held 4 cycles; wb_sel=1 with reg_write in WB; total 8 cycles; instret increments by 1.
- **BEQ:** zero=1 → pc_write=1, pc_src=1 in EXEC; zero=0 → pc_write=0; BNE (funct3=001) with zero=0 → taken; each case takes 3 cycles.
- **Memory timeout, TIMEOUT=4, mem_ready stuck low in FETCH:** state=HALT after 5 cycles in FETCH; halted=1, error=1; strobes 0 thereafter.
- **Timeout boundary:** mem_ready asserted on the 5th FETCH cycle (count=TIMEOUT) → no halt; DECODE follows.
- **Illegal opcode 1111111 and mid-instruction reset:** illegal opcode → HALT with error=0. reset=0 during MEM of an SW → no mem_write after the reset edge; FETCH with instret=0 after release.
